vn_collect_fifo: RTL
====================

// Module: vn_collect_fifo
// PURPOSE
//  Output collector directly downstream of the edge adder switch. Takes the 2-lane VN output
//  (vn bus + 2-bit lane valid) and packs 0/1/2 values per cycle into a single-word FIFO.
//  A ready/valid port drains the FIFO toward the output buffer/SRAM writer.
//  The upstream switch has no backpressure, so overflow is detected and flagged, never stalled.
// PARAMETERS
//  DATA_TYPE  32  width of one VN value (fp32 or int)
//  DEPTH      16  FIFO entries; power of two, >= 2
//  CNT_W      $clog2(DEPTH)+1  occupancy counter width (derived, not overridden)
// PORTS
//  CLK         in   1             clock, all state on rising edge
//  rst         in   1             synchronous reset, active-high
//  i_vn        in   2*DATA_TYPE   VN data; lane0=[DATA_TYPE-1:0], lane1=[2*DATA_TYPE-1:DATA_TYPE]
//  i_vn_valid  in   2             per-lane valid; bit0->lane0, bit1->lane1
//  i_clear     in   1             synchronous flush of contents (sticky flag kept)
//  i_ready     in   1             consumer ready
//  o_data      out  DATA_TYPE     head-of-FIFO value
//  o_valid     out  1             FIFO non-empty
//  o_count     out  CNT_W         current occupancy
//  o_full      out  1             o_count == DEPTH
//  o_overflow  out  1             sticky: a valid lane was dropped
// BEHAVIOUR
//  Reset (rst=1 at a clock edge): wr_ptr=rd_ptr=0, count=0, o_overflow=0 -> o_valid=0,
//   o_data=0, o_count=0, o_full=0. Same result when reset arrives mid-operation; memory contents
//   are don't-care. rst has priority over i_clear, push and pop.
//  Pop: pop = o_valid & i_ready; rd_ptr advances by 1 mod DEPTH.
//  Push: number of pushes per cycle = popcount(i_vn_valid), 0..2. Write order is always lane0
//   first, then lane1. Valid=2'b10 writes lane1 only, as one entry.
//  Space check: free = DEPTH - count + pop; a pop in the same cycle frees its slot.
//   pushes <= free: all written. pushes=2, free=1: lane0 written, lane1 dropped.
//   free=0: all dropped. Any drop sets o_overflow=1 until rst.
//  Counter: count_next = count + written - pop. Never exceeds DEPTH, never goes below 0.
//  Pointers: wr_ptr/rd_ptr are log2(DEPTH) bits and wrap DEPTH-1 -> 0. A 2-entry write
//   at DEPTH-1 puts lane0 at DEPTH-1 and lane1 at 0.
//  Show-ahead read: o_data = mem[rd_ptr] when o_valid, else 0. o_valid = (count != 0).
//  Latency: a value written at edge N appears at o_data/o_valid after edge N (one cycle).
//   There is no same-cycle bypass from i_vn to o_data.
//  Empty + push + i_ready: no pop this cycle. The data is visible next cycle.
//  i_clear: takes effect at the clock edge. Pointers and count go to 0, and any push or pop
//   in that cycle is discarded. o_overflow is kept.
//  o_data, o_valid, o_count and o_full hold while i_ready=0 and no push occurs.
//  All outputs come from registers; only o_data is decoded from the RAM read port.
// TESTING
//  1. Reset, then i_vn_valid=2'b11, lane0=0x3F800000, lane1=0x40000000, i_ready=0
//     -> o_count=2, o_data=0x3F800000; after one pop, o_data=0x40000000.
//  2. Single lanes: 2'b01 (A), then 2'b10 (B), then 2'b00 -> FIFO holds A,B in order;
//     o_count=2, o_overflow=0.
//  3. DEPTH=16, i_ready=0, eight cycles of 2'b11 -> o_full=1, o_count=16. Ninth 2'b11
//     -> o_overflow=1, count stays 16. Drain: the 16 values come out in lane0,lane1 order.
//  4. count=15, i_ready=1 with non-empty head, push 2'b11 -> both written
//     (free=2), count=16, o_overflow=0.
//  5. Wrap: push/pop steady to wr_ptr=15, then push 2'b11 (X,Y)
//     -> X read from entry 15, Y from entry 0; order preserved.
//  6. count=5, assert i_clear with push 2'b11 -> o_count=0, o_valid=0 next cycle.
//     Mid-stream rst -> all outputs 0, o_overflow=0.

Source files
------------

// File: rtl/vn_collect_fifo.sv
// Output collector behind the edge adder switch: packs 0/1/2 VN lane values per cycle
// into a single-word FIFO drained by a ready/valid port; drops are flagged, never stalled.
module vn_collect_fifo #(
  parameter int DATA_TYPE = 32,
  parameter int DEPTH     = 16,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [2*DATA_TYPE-1:0]   i_vn,
  input  logic [1:0]               i_vn_valid,
  input  logic                     i_clear,
  input  logic                     i_ready,
  output logic [DATA_TYPE-1:0]     o_data,
  output logic                     o_valid,
  output logic [CNT_W-1:0]         o_count,
  output logic                     o_full,
  output logic                     o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_TYPE-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;

  logic             pop;
  logic [1:0]       req;
  logic [1:0]       written;
  logic [CNT_W:0]   free;
  logic             drop;
  logic             we0, we1;
  logic [PTR_W-1:0] waddr0, waddr1;
  logic [DATA_TYPE-1:0] wdata0, wdata1;

  always_comb begin
    pop     = valid_q & i_ready;
    req     = {1'b0, i_vn_valid[0]} + {1'b0, i_vn_valid[1]};
    // A pop in the same cycle frees its slot for an incoming lane.
    free    = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(pop);
    drop    = (CNT_W+1)'(req) > free;
    written = drop ? free[1:0] : req;

    wdata0  = i_vn_valid[0] ? i_vn[DATA_TYPE-1:0] : i_vn[2*DATA_TYPE-1:DATA_TYPE];
    wdata1  = i_vn[2*DATA_TYPE-1:DATA_TYPE];
    waddr0  = wr_ptr_q;
    waddr1  = wr_ptr_q + PTR_W'(1);
    we0     = (written != 2'd0);
    we1     = (written == 2'd2);

    wr_ptr_d   = wr_ptr_q + PTR_W'(written);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(written) - CNT_W'(pop);
    overflow_d = overflow_q | drop;

    if (i_clear) begin
      we0        = 1'b0;
      we1        = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = overflow_q;
    end

    valid_d = (count_d != '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset; only the pointers and count define what is live.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      if (we0) mem_q[waddr0] <= wdata0;
      if (we1) mem_q[waddr1] <= wdata1;
    end
  end

  assign o_data     = valid_q ? mem_q[rd_ptr_q] : '0;
  assign o_valid    = valid_q;
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_overflow = overflow_q;

endmodule
